// File: rtl/pb_event_counter.sv
// Two-channel pushbutton event counter. Each raw button is synchronised,
// debounced and edge-detected into a one-cycle press strobe. The strobes
// drive a WIDTH-bit up/down counter with clear, load, wrap/saturate limits
// and terminal-count flags.

// One button channel: 2-flop synchroniser, debouncer, rising-edge strobe.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, stable;
  logic [CW-1:0] cnt;
  logic          flip;

  // The counter would reach DEBOUNCE_CYCLES on this edge.
  assign flip = (s2 != stable) && (cnt == LAST);

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      pulse <= flip && s2;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module pb_event_counter #(
  parameter int WIDTH           = 8,
  parameter int MAX_COUNT       = 2**WIDTH - 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SATURATE        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             pulse_up,
  output logic             pulse_dn,
  output logic             at_max,
  output logic             at_min,
  output logic             wrapped
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

  logic [1:0]       pulses;
  logic [WIDTH-1:0] load_clamped;

  // Channel 0 is up, channel 1 is down.
  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch [1:0] (
    .clk   (clk),
    .rst   (rst),
    .btn   ({btn_dn, btn_up}),
    .pulse (pulses)
  );

  assign pulse_up     = pulses[0];
  assign pulse_dn     = pulses[1];
  assign at_max       = (count == MAXV);
  assign at_min       = (count == '0);
  assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

  // Counter update: clear > load > opposing presses cancel > up > down.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= load_clamped;
      end else if (pulse_up && !pulse_dn) begin
        if (count == MAXV) begin
          if (SATURATE == 0) begin
            count   <= '0;
            wrapped <= 1'b1;
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end else if (pulse_dn && !pulse_up) begin
        if (count == '0) begin
          if (SATURATE == 0) begin
            count   <= MAXV;
            wrapped <= 1'b1;
          end
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pb_event_counter.sv
// Bench for pb_event_counter: three configurations share one stimulus
// stream (8-bit wrap, 4-bit/MAX 9 wrap, 4-bit/MAX 9 saturate) and are
// compared every cycle against a window-based behavioural model.
module tb_pb_event_counter;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, btn_up, btn_dn, clear, load;
  logic [7:0] lv8;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b, cnt_c;
  logic [2:0] pu, pd, amx, amn, wr;

  always #5 clk = ~clk;

  pb_event_counter #(.WIDTH(8), .MAX_COUNT(255), .DEBOUNCE_CYCLES(D), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clear(clear), .load(load),
    .load_val(lv8), .count(cnt_a), .pulse_up(pu[0]), .pulse_dn(pd[0]),
    .at_max(amx[0]), .at_min(amn[0]), .wrapped(wr[0]));
  pb_event_counter #(.WIDTH(4), .MAX_COUNT(9), .DEBOUNCE_CYCLES(D), .SATURATE(0)) u_b (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clear(clear), .load(load),
    .load_val(lv8[3:0]), .count(cnt_b), .pulse_up(pu[1]), .pulse_dn(pd[1]),
    .at_max(amx[1]), .at_min(amn[1]), .wrapped(wr[1]));
  pb_event_counter #(.WIDTH(4), .MAX_COUNT(9), .DEBOUNCE_CYCLES(D), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clear(clear), .load(load),
    .load_val(lv8[3:0]), .count(cnt_c), .pulse_up(pu[2]), .pulse_dn(pd[2]),
    .at_max(amx[2]), .at_min(amn[2]), .wrapped(wr[2]));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model. A channel's debounced level flips on the edge where
  // the synchronised value (raw delayed two edges) has disagreed with the
  // level for the last D edges since reset.
  int  mx[3]  = '{255, 9, 9};
  int  sat[3] = '{0, 0, 1};
  int  mc[3], mw[3];
  bit  stab[2], mp[2];
  bit  raw_h[2][64];
  int  n_edge;

  function automatic bit rawv(input int c, input int k);
    return (k < 1) ? 1'b0 : raw_h[c][k % 64];
  endfunction

  task automatic model_edge();
    bit flip;
    int lv;
    if (rst) begin
      n_edge = 0;
      for (int c = 0; c < 2; c++) begin stab[c] = 0; mp[c] = 0; end
      for (int i = 0; i < 3; i++) begin mc[i] = 0; mw[i] = 0; end
      return;
    end
    for (int i = 0; i < 3; i++) begin
      lv = (i == 0) ? int'(lv8) : int'(lv8 & 8'hF);
      mw[i] = 0;
      if (clear) mc[i] = 0;
      else if (load) mc[i] = (lv > mx[i]) ? mx[i] : lv;
      else if (mp[0] && !mp[1]) begin
        if (mc[i] < mx[i]) mc[i]++;
        else if (sat[i] == 0) begin mc[i] = 0; mw[i] = 1; end
      end else if (mp[1] && !mp[0]) begin
        if (mc[i] > 0) mc[i]--;
        else if (sat[i] == 0) begin mc[i] = mx[i]; mw[i] = 1; end
      end
    end
    n_edge++;
    raw_h[0][n_edge % 64] = btn_up;
    raw_h[1][n_edge % 64] = btn_dn;
    for (int c = 0; c < 2; c++) begin
      flip = (n_edge >= D);
      for (int m = n_edge - D + 1; m <= n_edge; m++)
        if (rawv(c, m - 2) == stab[c]) flip = 0;
      mp[c] = flip && !stab[c];
      if (flip) stab[c] = !stab[c];
    end
  endtask

  task automatic compare_all();
    int cnt[3];
    cnt[0] = cnt_a; cnt[1] = cnt_b; cnt[2] = cnt_c;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count%0d", i), cnt[i], mc[i]);
      chk($sformatf("pulse_up%0d", i), pu[i], mp[0]);
      chk($sformatf("pulse_dn%0d", i), pd[i], mp[1]);
      chk($sformatf("wrapped%0d", i), wr[i], mw[i]);
      chk($sformatf("at_max%0d", i), amx[i], int'(mc[i] == mx[i]));
      chk($sformatf("at_min%0d", i), amn[i], int'(mc[i] == 0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // One press-and-release on the chosen channels.
  task automatic press(input bit up, input bit dn);
    btn_up = up; btn_dn = dn;
    steps(12);
    btn_up = 0; btn_dn = 0;
    steps(12);
  endtask

  task automatic do_load(input int v);
    lv8 = 8'(v); load = 1; step(); load = 0;
  endtask

  int seen, both;

  initial begin
    rst = 1; btn_up = 0; btn_dn = 0; clear = 0; load = 0; lv8 = 0;
    steps(3);
    rst = 0;
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_pulse", pu[0], 0);

    // Held press: strobe after the sixth edge, count on the seventh.
    btn_up = 1;
    steps(5);
    chk("hold_pre", pu[0], 0);
    step();
    chk("hold_pulse", pu[0], 1);
    step();
    chk("hold_cnt", cnt_a, 1);
    chk("hold_pulse_end", pu[0], 0);
    steps(20);
    chk("hold_no_repeat", cnt_a, 1);
    btn_up = 0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin step(); seen += pu[0]; end
    chk("release_no_pulse", seen, 0);

    // Bounce then settle: exactly one strobe.
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      btn_up = ~k[0];
      for (int j = 0; j < 2; j++) begin step(); seen += pu[0]; end
    end
    btn_up = 1;
    for (int k = 0; k < 12; k++) begin step(); seen += pu[0]; end
    btn_up = 0;
    steps(12);
    chk("bounce_pulses", seen, 1);
    chk("bounce_cnt", cnt_a, 2);

    // Limits at MAX_COUNT=9 for wrap and saturate variants.
    do_load(9);
    seen = 0;
    btn_up = 1;
    for (int k = 0; k < 12; k++) begin step(); seen += wr[1]; end
    btn_up = 0;
    steps(12);
    chk("wrap_up_cnt", cnt_b, 0);
    chk("wrap_up_seen", seen, 1);
    chk("wrap_up_min", amn[1], 1);
    chk("sat_up_cnt", cnt_c, 9);
    press(0, 1);
    chk("wrap_dn_cnt", cnt_b, 9);
    chk("wrap_dn_max", amx[1], 1);
    do_load(0);
    press(0, 1);
    chk("sat_dn_cnt", cnt_c, 0);

    // Simultaneous presses cancel.
    both = 0;
    btn_up = 1; btn_dn = 1;
    for (int k = 0; k < 12; k++) begin step(); both += (pu[0] & pd[0]); end
    btn_up = 0; btn_dn = 0;
    steps(12);
    chk("simul_both", both, 1);
    chk("simul_cnt", cnt_c, 0);

    // clear beats load; load clamps.
    lv8 = 5; clear = 1; load = 1; step(); clear = 0; load = 0;
    chk("clr_over_load", cnt_b, 0);
    do_load(12);
    chk("load_clamp", cnt_b, 9);
    chk("load_noclamp", cnt_a, 12);

    // Reset two cycles into the debounce window.
    btn_up = 1;
    steps(4);
    rst = 1; step(); rst = 0;
    chk("midrst_cnt", cnt_a, 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin step(); seen += pu[0]; end
    btn_up = 0;
    steps(12);
    chk("midrst_pulses", seen, 1);
    chk("midrst_cnt_after", cnt_a, 1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(5) == 0) btn_up = ~btn_up;
      if ($urandom_range(5) == 0) btn_dn = ~btn_dn;
      clear = ($urandom_range(60) == 0);
      load  = ($urandom_range(40) == 0);
      lv8   = 8'($urandom_range(255));
      if (load && $urandom_range(1) == 0) lv8 = 8'($urandom_range(15));
      rst   = ($urandom_range(400) == 0);
      step();
    end
    rst = 0; clear = 0; load = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pb_event_counter.md
Name: pb_event_counter

Overview:
- Parametrised successor to the single-button pulse counter: two pushbutton channels (up, down), each with a 2-flop synchroniser, a debouncer and a rising-edge pulse generator.
- Drives a WIDTH-bit up/down counter clocked only by clk (no derived clocks), with wrap or saturate mode, synchronous clear and load, and terminal-count flags.
- Sits between raw board pushbuttons and display/control logic.

Parameters:
- WIDTH, 8, counter width in bits.
- MAX_COUNT, 2**WIDTH-1, upper count limit; legal count range is 0..MAX_COUNT; must be <= 2**WIDTH-1.
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced state before the debounced state flips; must be >= 1.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- btn_up  input  1  raw asynchronous up pushbutton, active-high.
- btn_dn  input  1  raw asynchronous down pushbutton, active-high.
- clear  input  1  synchronous clear of count to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  load value; values > MAX_COUNT are clamped to MAX_COUNT.
- count  output  WIDTH  current count.
- pulse_up  output  1  one-cycle debounced press strobe, up channel.
- pulse_dn  output  1  one-cycle debounced press strobe, down channel.
- at_max  output  1  combinational: count == MAX_COUNT.
- at_min  output  1  combinational: count == 0.
- wrapped  output  1  one-cycle strobe when a wrap occurs (SATURATE=0 only).

Behaviour:
- Reset (rst=1 at an edge): sync flops, debounced states, debounce counters, pulse_up, pulse_dn, wrapped and count all go to 0. Reset overrides every other input. Reset mid-debounce discards partial progress.
- Synchroniser: s1 <= btn; s2 <= s1. Raw rise sampled at edge E1 appears on s2 at edge E1+1.
- Debouncer, per channel: if s2 == stable, the debounce counter goes to 0. Otherwise it increments. On the cycle it would reach DEBOUNCE_CYCLES, stable <= s2 and the counter goes to 0.
- Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles resets progress and causes no flip. Release is debounced identically.
- Pulse: pulse_x is registered. It is 1 for exactly one cycle, asserted on the same edge where stable goes 0->1. No pulse on release. A held button gives exactly one pulse.
- Latency: with a raw rise sampled at E1, stable and pulse rise at edge E1+1+DEBOUNCE_CYCLES. Count updates at edge E1+2+DEBOUNCE_CYCLES. For DEBOUNCE_CYCLES=4 this is 6 edges after E1.
- Count update priority, per edge:
  - clear → 0.
  - else load → min(load_val, MAX_COUNT).
  - else pulse_up && pulse_dn → hold.
  - else pulse_up → +1.
  - else pulse_dn → -1.
  - else hold.
- Limits, SATURATE=0: up at MAX_COUNT gives 0; down at 0 gives MAX_COUNT. wrapped=1 in the cycle after the wrapping edge, for one cycle.
- Limits, SATURATE=1: up at MAX_COUNT and down at 0 hold the count. wrapped stays 0.
- wrapped is never set by clear or load.
- Arithmetic is WIDTH-bit unsigned. MAX_COUNT < 2**WIDTH-1 wraps at MAX_COUNT, not at 2**WIDTH-1.
- clear and load do not affect synchroniser or debouncer state. A pulse coincident with clear or load is dropped.

Test Plan:
- Reset, then hold btn_up high from E1 (DEBOUNCE_CYCLES=4) → pulse_up high for the single cycle following edge E1+5; count 0→1 at edge E1+6; no further increments while held; release gives no pulse.
- Bounce: btn_up toggles 1,0,1,0 each 2 cycles, then holds high → exactly one pulse_up, and only after 4 stable synchronised cycles; count=1.
- Wrap (WIDTH=4, MAX_COUNT=9, SATURATE=0): load 9, one up press → count=0, wrapped one cycle, at_min=1; then one down press → count=9, wrapped one cycle, at_max=1.
- Saturate (SATURATE=1, MAX_COUNT=9): load 9, up press → count stays 9, wrapped=0; load 0, down press → count stays 0.
- Simultaneous: up and down pressed the same cycle → pulse_up and pulse_dn coincide, count unchanged. clear and load asserted together with load_val=5 → count=0. load_val=12 with MAX_COUNT=9 → count=9.
- Reset mid-debounce: assert rst 2 cycles into the debounce window of a press → all outputs 0; after rst deasserts, the still-held button is re-debounced from scratch and counts exactly once.
